result_stream_serializer_16ch: RTL and testbench



---
 rtl/result_stream_serializer_16ch.sv | 109 ++++++++++
 tb/tb_result_stream_serializer_16ch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_serializer_16ch.sv
// Result stream serializer: accepts wide result vectors into a 2-entry queue
// and emits each one as OUT_W-bit beats, lane 0 first, flagging the last beat
// of every tile and counting completed tiles.
module result_stream_serializer_16ch #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ROW_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   in_vector,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROW_W-1:0]          tile_rows,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic [15:0]               tiles_done
);

  localparam int unsigned VEC_W  = LANES * DATA_W;
  localparam int unsigned BEATS  = VEC_W / OUT_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (!((OUT_W == 32) || (OUT_W == 64) || (OUT_W == 128) ||
        (OUT_W == 256) || (OUT_W == 512)) || ((VEC_W % OUT_W) != 0)) begin : g_bad_out_w
    $error("result_stream_serializer_16ch: illegal OUT_W");
  end

  logic [VEC_W-1:0]             vec_q [2];
  logic [1:0]                   last_q;
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   count;
  logic [BEAT_W-1:0]            beat;
  logic [ROW_W-1:0]             row_cnt;
  logic [ROW_W-1:0]             eff_rows;
  logic [ROW_W-1:0]             eff_now;
  logic                         tag_last;
  logic                         push;
  logic                         out_fire;
  logic                         at_last_beat;
  logic                         pop;
  logic [BEATS-1:0][OUT_W-1:0]  head_beats;

  // Handshakes, head beat selection and tile tagging of the incoming vector
  always_comb begin
    in_ready     = !rst && (count != 2'd2);
    push         = in_valid && in_ready;
    out_valid    = (count != 2'd0);
    busy         = out_valid;
    at_last_beat = (beat == LAST_BEAT);
    out_fire     = out_valid && out_ready;
    pop          = out_fire && at_last_beat;
    head_beats   = vec_q[rd_ptr];
    out_data     = out_valid ? head_beats[beat] : '0;
    out_last     = out_valid && last_q[rd_ptr] && at_last_beat;
    // tile length is latched only on the first vector of a tile; 0 means 1
    if (row_cnt == '0)
      eff_now = (tile_rows == '0) ? ROW_W'(1) : tile_rows;
    else
      eff_now = eff_rows;
    tag_last = (row_cnt == (eff_now - ROW_W'(1)));
  end

  // Queue payload storage; contents are don't-care while the entry is empty
  always_ff @(posedge clk) begin
    if (push) begin
      vec_q[wr_ptr]  <= in_vector;
      last_q[wr_ptr] <= tag_last;
    end
  end

  // Queue pointers, occupancy, beat/row counters and completed-tile count
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat       <= '0;
      row_cnt    <= '0;
      eff_rows   <= ROW_W'(1);
      tiles_done <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        eff_rows <= eff_now;
        row_cnt  <= tag_last ? '0 : row_cnt + ROW_W'(1);
      end
      if (out_fire) begin
        beat <= at_last_beat ? '0 : beat + BEAT_W'(1);
        if (at_last_beat)
          rd_ptr <= ~rd_ptr;
        if (out_last)
          tiles_done <= tiles_done + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_result_stream_serializer_16ch.sv
// Scoreboard bench: the driver pushes the expected beats of every accepted
// vector into a queue; a negedge monitor compares the DUT stream against it.
module tb_result_stream_serializer_16ch;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_vector;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   tile_rows;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [15:0]  tiles_done;

  logic [511:0] v128;
  logic         val128;
  logic         rdy128;
  logic [7:0]   rows128;
  logic [127:0] o128_data;
  logic         o128_valid;
  logic         o128_ready;
  logic         o128_last;
  logic         busy128;
  logic [15:0]  td128;

  always #5 clk = ~clk;

  result_stream_serializer_16ch dut (
    .clk(clk), .rst(rst), .in_vector(in_vector), .in_valid(in_valid),
    .in_ready(in_ready), .tile_rows(tile_rows), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .tiles_done(tiles_done)
  );

  result_stream_serializer_16ch #(.OUT_W(128)) dut128 (
    .clk(clk), .rst(rst), .in_vector(v128), .in_valid(val128),
    .in_ready(rdy128), .tile_rows(rows128), .out_data(o128_data),
    .out_valid(o128_valid), .out_ready(o128_ready), .out_last(o128_last),
    .busy(busy128), .tiles_done(td128)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  logic [15:0] exp_tiles = '0;
  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned ready_mode = 0;   // 0: always ready, 1: random, 3: manual
  logic [31:0] prev_data;
  logic        prev_last;
  logic        prev_stall = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present one vector and wait (bounded) for it to be accepted; on acceptance
  // queue its 16 expected beats, last beat flagged if it closes a tile.
  task automatic send_vec(input logic [511:0] v, input logic [7:0] rows, input logic last);
    int unsigned n = 0;
    bit          done = 0;
    beat_t       e;
    in_vector = v;
    tile_rows = rows;
    in_valid  = 1'b1;
    while (!done) begin
      #7;
      if (in_ready) begin
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          check("accept_timeout", 1, 0);
          done = 1;
        end
        @(posedge clk); #1;
      end
    end
    if (n <= 200) begin
      for (int b = 0; b < 16; b++) begin
        e.d = v[b*32 +: 32];
        e.l = last && (b == 15);
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // A tile spans max(rows,1) vectors; later vectors may carry other tile_rows
  task automatic send_tile(input logic [7:0] rows, input bit change_mid);
    int unsigned eff = (rows == 0) ? 1 : rows;
    logic [7:0]  r;
    for (int unsigned k = 0; k < eff; k++) begin
      r = (k == 0 || !change_mid) ? rows : 8'($urandom_range(0, 255));
      send_vec(rand_vec(), r, k == eff - 1);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  // Downstream ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare the DUT stream and status against the scoreboard
  always @(negedge clk) begin
    int unsigned nvec;
    if (rst) begin
      q.delete();
      exp_tiles  = '0;
      prev_stall = 1'b0;
      check("in_ready_in_reset", in_ready, 0);
    end else begin
      nvec = (q.size() + 15) / 16;
      check("out_valid", out_valid, q.size() != 0);
      check("busy", busy, q.size() != 0);
      check("in_ready", in_ready, nvec < 2);
      check("tiles_done", tiles_done, exp_tiles);
      if (prev_stall) begin
        check("stall_data_stable", out_data, prev_data);
        check("stall_last_stable", out_last, prev_last);
      end
      if (out_valid && q.size() != 0) begin
        check("out_data", out_data, q[0].d);
        check("out_last", out_last, q[0].l);
        if (out_ready) begin
          if (q[0].l) exp_tiles = exp_tiles + 16'd1;
          void'(q.pop_front());
        end
      end else if (!out_valid) begin
        check("out_data_idle", out_data, 0);
        check("out_last_idle", out_last, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    logic [511:0] v;
    logic [127:0] e128;
    rst = 1'b1; in_valid = 1'b0; in_vector = '0; tile_rows = '0;
    val128 = 1'b0; v128 = '0; rows128 = 8'd1; o128_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single vector, lane i = 0x100+i
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'h100 + 32'(i);
    send_vec(v, 8'd1, 1'b1);
    drain();

    // back-to-back 4-row tile, then the same under random backpressure
    ready_mode = 0; send_tile(8'd4, 1'b0); drain();
    ready_mode = 1; send_tile(8'd4, 1'b0); drain();

    // tile_rows = 0 is one vector; mid-tile changes are ignored
    ready_mode = 0; send_tile(8'd0, 1'b0); send_tile(8'd3, 1'b1); drain();

    // randomized tiles
    repeat (20) begin
      ready_mode = $urandom_range(0, 1);
      send_tile(8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0; drain();

    // reset with two entries queued and the head at beat 7
    ready_mode = 3; out_ready = 1'b0;
    send_vec(rand_vec(), 8'd4, 1'b0);
    send_vec(rand_vec(), 8'd4, 1'b0);
    out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1 out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ready_mode = 0;
    send_tile(8'd1, 1'b0); drain();

    // 128-bit beat build, lane i = i
    for (int i = 0; i < 16; i++) v128[i*32 +: 32] = 32'(i);
    val128 = 1'b1;
    #7 check("w128_in_ready", rdy128, 1);
    @(posedge clk); #1 val128 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) e128[k*32 +: 32] = 32'(4 * b + k);
      check("w128_valid", o128_valid, 1);
      check("w128_data", o128_data, e128);
      check("w128_last", o128_last, b == 3);
    end
    @(negedge clk);
    check("w128_idle", o128_valid, 0);
    check("w128_tiles", td128, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
